// File: rtl/monitor_sampler.sv
// monitor_sampler
//   Block-averages four signed 16-bit channels over 2^AVG_SHIFT samples and
//   forwards each completed average to a slow monitor. A holdoff counter keeps
//   the monitor from being fed faster than it can print a line. Blocks that
//   complete while the holdoff is running are discarded and counted.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   i_en                sample strobe, one sample per high cycle
//   i_val0..i_val3      signed channel samples, valid while i_en=1
//   o_en                one-cycle pulse: o_val0..3 hold a new averaged line
//   o_val0..o_val3      averaged channel values, held between pulses
//   o_drop_cnt          saturating count of blocks discarded by the holdoff

// One channel: accumulator plus the floor-average of the block that is
// completing on the current sample.
module monitor_sampler_lane #(
    parameter int AVG_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               add,
    input  logic               clr,
    input  logic signed [15:0] val,
    output logic signed [15:0] res
);
    localparam int AW = 16 + AVG_SHIFT;

    // Holds at most N-1 samples, so acc+val (N samples) always fits in AW bits.
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;

    assign sum = acc + AW'(val);
    // Arithmetic shift floors toward -inf; the average always fits in 16 bits.
    assign res = 16'(sum >>> AVG_SHIFT);

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (add)
            acc <= sum;
    end
endmodule

module monitor_sampler #(
    parameter int          AVG_SHIFT   = 4,
    parameter logic [23:0] HOLD_CYCLES = 24'd70000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic signed [15:0] i_val0,
    input  logic signed [15:0] i_val1,
    input  logic signed [15:0] i_val2,
    input  logic signed [15:0] i_val3,
    output logic               o_en,
    output logic signed [15:0] o_val0,
    output logic signed [15:0] o_val1,
    output logic signed [15:0] o_val2,
    output logic signed [15:0] o_val3,
    output logic [7:0]         o_drop_cnt
);
    localparam int NUM_LANES = 4;

    typedef enum logic {READY, HOLD} st_t;

    logic [NUM_LANES-1:0][15:0] lane_in;
    logic [NUM_LANES-1:0][15:0] lane_res;
    logic [NUM_LANES-1:0][15:0] val_q;
    logic                       blk_done;
    logic                       accept;
    logic                       drop;
    st_t                        st, st_nxt;
    logic [23:0]                hold_cnt, hold_nxt;

    assign lane_in = {i_val3, i_val2, i_val1, i_val0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        monitor_sampler_lane #(.AVG_SHIFT(AVG_SHIFT)) u_lane (
            .clk (clk),
            .rst (rst),
            .add (i_en),
            .clr (blk_done),
            .val (lane_in[g]),
            .res (lane_res[g])
        );
    end

    // Sample counter; wrapping from N-1 to 0 is the block-complete clear.
    if (AVG_SHIFT > 0) begin : g_cnt
        logic [AVG_SHIFT-1:0] scnt;
        always_ff @(posedge clk) begin
            if (rst)
                scnt <= '0;
            else if (i_en)
                scnt <= scnt + 1'b1;
        end
        assign blk_done = i_en && (scnt == '1);
    end else begin : g_nocnt
        assign blk_done = i_en;
    end

    // Holdoff FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= READY;
            hold_cnt <= '0;
        end else begin
            st       <= st_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Holdoff FSM: next state. HOLD counts down every cycle; a zero load
    // (HOLD_CYCLES==0) keeps the FSM in READY.
    always_comb begin
        hold_nxt = hold_cnt;
        case (st)
            READY:   if (blk_done) hold_nxt = HOLD_CYCLES;
            HOLD:    hold_nxt = hold_cnt - 24'd1;
            default: hold_nxt = '0;
        endcase
        st_nxt = (hold_nxt == '0) ? READY : HOLD;
    end

    // Holdoff FSM: outputs
    always_comb begin
        accept = blk_done && (st == READY);
        drop   = blk_done && (st == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_en       <= 1'b0;
            val_q      <= '0;
            o_drop_cnt <= '0;
        end else begin
            o_en <= accept;
            if (accept)
                val_q <= lane_res;
            if (drop && o_drop_cnt != 8'hFF)
                o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    assign o_val0 = val_q[0];
    assign o_val1 = val_q[1];
    assign o_val2 = val_q[2];
    assign o_val3 = val_q[3];
endmodule

// File: tb/tb_monitor_sampler.sv
// Scoreboard bench: three instances (AVG_SHIFT,HOLD_CYCLES) = (2,10), (0,0),
// (0,1000) share the same stimulus. A reference model works on whole blocks
// and pulse timestamps; a negedge monitor pops expected lines on every o_en.
module tb_monitor_sampler;
    localparam int ND = 3;
    localparam int SH [ND] = '{2, 0, 0};
    localparam int HC [ND] = '{10, 0, 1000};

    typedef struct packed {
        int                e;
        logic [3:0][15:0]  v;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   i_en = 1'b0;
    logic [3:0][15:0]       iv = '0;
    logic                   den   [ND];
    logic [3:0][15:0]       dv    [ND];
    logic [7:0]             ddrop [ND];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    exp_t q0[$], q1[$], q2[$];

    longint msum  [ND][4];
    int     mcnt  [ND];
    int     mlast [ND];
    int     mdrop [ND];
    int     mheld [ND][4];

    always #5 clk = ~clk;

    monitor_sampler #(.AVG_SHIFT(2), .HOLD_CYCLES(24'd10)) u_d0 (
        .clk(clk), .rst(rst), .i_en(i_en),
        .i_val0(iv[0]), .i_val1(iv[1]), .i_val2(iv[2]), .i_val3(iv[3]),
        .o_en(den[0]), .o_val0(dv[0][0]), .o_val1(dv[0][1]), .o_val2(dv[0][2]),
        .o_val3(dv[0][3]), .o_drop_cnt(ddrop[0]));
    monitor_sampler #(.AVG_SHIFT(0), .HOLD_CYCLES(24'd0)) u_d1 (
        .clk(clk), .rst(rst), .i_en(i_en),
        .i_val0(iv[0]), .i_val1(iv[1]), .i_val2(iv[2]), .i_val3(iv[3]),
        .o_en(den[1]), .o_val0(dv[1][0]), .o_val1(dv[1][1]), .o_val2(dv[1][2]),
        .o_val3(dv[1][3]), .o_drop_cnt(ddrop[1]));
    monitor_sampler #(.AVG_SHIFT(0), .HOLD_CYCLES(24'd1000)) u_d2 (
        .clk(clk), .rst(rst), .i_en(i_en),
        .i_val0(iv[0]), .i_val1(iv[1]), .i_val2(iv[2]), .i_val3(iv[3]),
        .o_en(den[2]), .o_val0(dv[2][0]), .o_val1(dv[2][1]), .o_val2(dv[2][2]),
        .o_val3(dv[2][3]), .o_drop_cnt(ddrop[2]));

    task automatic push_exp(input int d, input exp_t x);
        case (d)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Block-level reference: floor average via integer division, holdoff as
    // "next accept no earlier than HOLD_CYCLES+1 edges after the last one".
    task automatic model_edge(input bit r, input bit en, input logic [3:0][15:0] v);
        for (int d = 0; d < ND; d++) begin
            if (r) begin
                for (int k = 0; k < 4; k++) begin
                    msum[d][k]  = 0;
                    mheld[d][k] = 0;
                end
                mcnt[d]  = 0;
                mlast[d] = -1;
                mdrop[d] = 0;
            end else if (en) begin
                for (int k = 0; k < 4; k++)
                    msum[d][k] += longint'($signed(v[k]));
                mcnt[d]++;
                if (mcnt[d] == (1 << SH[d])) begin
                    longint n;
                    exp_t   x;
                    n = longint'(1 << SH[d]);
                    x.e = edge_n;
                    x.v = '0;
                    for (int k = 0; k < 4; k++) begin
                        longint qv;
                        qv = msum[d][k] / n;
                        if ((msum[d][k] % n) != 0 && msum[d][k] < 0)
                            qv -= 1;
                        x.v[k] = 16'(qv);
                        msum[d][k] = 0;
                    end
                    mcnt[d] = 0;
                    if (mlast[d] < 0 || (edge_n - mlast[d]) >= HC[d] + 1) begin
                        mlast[d] = edge_n;
                        for (int k = 0; k < 4; k++)
                            mheld[d][k] = int'($signed(x.v[k]));
                        push_exp(d, x);
                    end else if (mdrop[d] < 255) begin
                        mdrop[d]++;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input int a, input int b,
                        input int c, input int e);
        logic [3:0][15:0] v;
        v = {16'(e), 16'(c), 16'(b), 16'(a)};
        rst  = r;
        i_en = en;
        iv   = v;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(r, en, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_drop_d%0d", tag, d), int'(ddrop[d]), mdrop[d]);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_val_d%0d_%0d", tag, d, k), int'($signed(dv[d][k])), mheld[d][k]);
        end
    endtask

    // Monitor: every o_en must match the next expected line, at the expected edge.
    task automatic check_pulse(input int d);
        exp_t x;
        bit   have;
        have = 1'b0;
        x    = '0;
        case (d)
            0: if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL pulse_d%0d unexpected o_en at edge %0d", d, edge_n);
        end else if (x.e != edge_n || dv[d] != x.v) begin
            errors++;
            $display("FAIL pulse_d%0d got edge %0d val %h exp edge %0d val %h",
                     d, edge_n, dv[d], x.e, x.v);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++)
            if (den[d] === 1'b1)
                check_pulse(d);
    end

    initial begin
        // Reset
        step(1'b1, 1'b1, 5, 5, 5, 5);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_en_d%0d", d), int'(den[d]), 0);
            chk($sformatf("rst_drop_d%0d", d), int'(ddrop[d]), 0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("rst_val_d%0d_%0d", d, k), int'($signed(dv[d][k])), 0);
        end

        // Basic average, floor rounding, extremes
        step(1'b0, 1'b1, 100, -1, -32768, 32767);
        step(1'b0, 1'b1, 200, -2, -32768, 32767);
        step(1'b0, 1'b1, 300, -2, -32768, 32767);
        step(1'b0, 1'b1, 400, -2, -32768, 32767);
        chk("avg_en_next_cycle", int'(den[0]), 1);
        idle(1);
        chk("avg_en_one_cycle", int'(den[0]), 0);
        chk("avg_v0", int'($signed(dv[0][0])), 250);
        chk("floor_v1", int'($signed(dv[0][1])), -2);
        chk("min_v2", int'($signed(dv[0][2])), -32768);
        chk("max_v3", int'($signed(dv[0][3])), 32767);
        chk("pass_v0", int'($signed(dv[1][0])), 400);

        // Holdoff: block completing 5 edges after the accepted one is dropped
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1, 1, 1, 1);
        idle(1);
        chk("hold_drop_cnt", int'(ddrop[0]), 1);
        chk("hold_val_kept", int'($signed(dv[0][0])), 250);
        idle(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 40, 40, 40, 40);
        idle(1);
        chk("hold_new_val", int'($signed(dv[0][0])), 40);
        chk_state("hold");

        // Reset mid-block
        step(1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1000, 1000, 1000, 1000);
        step(1'b0, 1'b1, 1000, 1000, 1000, 1000);
        step(1'b1, 1'b1, 1000, 1000, 1000, 1000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8, 8, 8, 8);
        idle(1);
        chk("rstmid_v0", int'($signed(dv[0][0])), 8);
        chk("rstmid_drop", int'(ddrop[0]), 0);
        chk_state("rstmid");

        // Drop counter saturation
        step(1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        idle(1);
        chk("sat_drop_d2", int'(ddrop[2]), 255);
        chk_state("sat");

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 60,
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            if (i % 250 == 249)
                chk_state("rand");
        end

        idle(3);
        chk_state("end");
        for (int d = 0; d < ND; d++)
            chk($sformatf("drain_d%0d", d), qsize(d), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/monitor_sampler.md
MONITOR_SAMPLER -- requirements
Module: monitor_sampler

Interface
REQ-001 SHALL have parameter AVG_SHIFT, default 4: log2 of samples averaged per output block; legal range 0..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 24'd70000: minimum clk cycles between o_en pulses, which covers one 32-byte monitor line at CLK_DIV=217.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_en, input, 1 bit: sample strobe, one sample per high cycle.
REQ-006 SHALL have ports i_val0..i_val3, input, signed 16 bits each: channel samples, valid when i_en=1.
REQ-007 SHALL have port o_en, output, 1 bit: one-cycle pulse, meaning o_val0..3 hold a new averaged line (drives the monitor's i_en).
REQ-008 SHALL have ports o_val0..o_val3, output, signed 16 bits each: averaged channel values, stable between pulses.
REQ-009 SHALL have port o_drop_cnt, output, 8 bits: count of completed blocks discarded by holdoff, saturating.

Function
REQ-010 SHALL keep one signed accumulator per channel, width 16+AVG_SHIFT, which cannot overflow.
REQ-011 SHALL keep sample counter scnt of AVG_SHIFT bits (none when AVG_SHIFT=0); N = 2^AVG_SHIFT.
REQ-012 SHALL, on an i_en edge with scnt<N-1, add each i_valk to acck and increment scnt.
REQ-013 SHALL, on an i_en edge with scnt==N-1 (block complete), clear all accumulators and scnt in the same edge.
REQ-014 SHALL compute the block result as (acck + i_valk) >>> AVG_SHIFT, an arithmetic shift rounding toward -inf, truncated to 16 bits (range is guaranteed to fit).
REQ-015 SHALL have holdoff FSM states READY (hold_cnt==0) and HOLD (hold_cnt!=0); hold_cnt is 24 bits.
REQ-016 SHALL, in HOLD, decrement hold_cnt by 1 every clk cycle, regardless of i_en.
REQ-017 SHALL, on block complete in READY: register results into o_val0..3; assert o_en for exactly the next cycle (latency 1 clk after the final i_en edge); load hold_cnt=HOLD_CYCLES.
REQ-018 SHALL, on block complete in HOLD (including hold_cnt==1 at that edge): leave o_val unchanged; keep o_en low; increment o_drop_cnt, saturating at 255.
REQ-019 SHALL, when HOLD_CYCLES==0, never enter HOLD, so every block completion pulses o_en.
REQ-020 SHALL keep o_val0..3 constant at all times except the edge that asserts o_en.
REQ-021 SHALL never assert o_en for two consecutive cycles; pulse spacing SHALL be >= HOLD_CYCLES+1 cycles when HOLD_CYCLES>0.
REQ-022 SHALL ignore i_valk when i_en=0.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear all accumulators, scnt, hold_cnt and o_drop_cnt to 0, set o_en=0 and o_val0..3=0, and enter READY.
REQ-024 SHALL discard a partial block on reset; the first post-reset block averages only post-reset samples.
REQ-025 SHALL give rst priority over a simultaneous i_en.

Verification
REQ-026 SHALL verify basic averaging (AVG_SHIFT=2, HOLD_CYCLES=10): i_val0 = 100,200,300,400 on 4 i_en cycles -> o_en high one cycle after the 4th sample, o_val0=250.
REQ-027 SHALL verify floor rounding (AVG_SHIFT=2): i_val1 = -1,-2,-2,-2 -> o_val1=-2 (sum -7; -1.75 floors to -2).
REQ-028 SHALL verify extremes without overflow (AVG_SHIFT=2): 4x -32768 on i_val2 -> -32768; 4x 32767 on i_val3 -> 32767.
REQ-029 SHALL verify holdoff drop (AVG_SHIFT=2, HOLD_CYCLES=10): second block completes 5 cycles after the first o_en -> no o_en, o_drop_cnt=1, o_val unchanged; third block completing at cycle >=11 -> o_en with new values.
REQ-030 SHALL verify reset mid-block: rst after 2 samples of 1000, then 4 samples of 8 -> o_val0=8, o_drop_cnt=0.
REQ-031 SHALL verify passthrough (AVG_SHIFT=0, HOLD_CYCLES=0): each i_en -> o_en next cycle with o_valk=i_valk; 300 forced drops in another config -> o_drop_cnt saturates at 255.
